// File: rtl/counter_step_decoder.sv
// counter_step_decoder: classifies successive counter samples as HOLD/INC/DEC/NEG/ERR,
// keeps saturating per-operation counts and captures the first illegal step.
module counter_step_decoder #(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          s_valid,
    input  logic [N-1:0]  s_data,
    output logic          op_valid,
    output logic [2:0]    op_code,
    output logic          err,
    output logic          err_sticky,
    output logic [N-1:0]  err_prev,
    output logic [N-1:0]  err_cur,
    output logic [CW-1:0] cnt_hold,
    output logic [CW-1:0] cnt_inc,
    output logic [CW-1:0] cnt_dec,
    output logic [CW-1:0] cnt_neg,
    output logic [CW-1:0] cnt_err
);
    localparam logic [0:0]    EMPTY   = 1'b0;
    localparam logic [0:0]    TRACK   = 1'b1;
    localparam logic [2:0]    OP_HOLD = 3'd0;
    localparam logic [2:0]    OP_INC  = 3'd1;
    localparam logic [2:0]    OP_DEC  = 3'd2;
    localparam logic [2:0]    OP_NEG  = 3'd3;
    localparam logic [2:0]    OP_ERR  = 3'd7;
    localparam logic [N-1:0]  ONE     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CONE    = {{(CW-1){1'b0}}, 1'b1};

    logic [0:0]    state_q, state_d;
    logic [N-1:0]  prev_q, prev_d;
    logic          op_valid_q, op_valid_d;
    logic [2:0]    op_code_q, op_code_d;
    logic          err_q, err_d;
    logic          err_sticky_q, err_sticky_d;
    logic [N-1:0]  err_prev_q, err_prev_d;
    logic [N-1:0]  err_cur_q, err_cur_d;
    logic [CW-1:0] cnt_q [0:4];
    logic [CW-1:0] cnt_d [0:4];
    logic [2:0]    step_code;
    logic [2:0]    step_idx;

    always_comb begin
        // Priority order makes the NEG/HOLD overlaps at 0 and 2^(N-1) decode as HOLD
        step_code = (s_data == prev_q)        ? OP_HOLD :
                    (s_data == prev_q + ONE)  ? OP_INC  :
                    (s_data == prev_q - ONE)  ? OP_DEC  :
                    (s_data == ~prev_q + ONE) ? OP_NEG  : OP_ERR;
        step_idx     = (step_code == OP_ERR) ? 3'd4 : step_code;
        state_d      = state_q;
        prev_d       = prev_q;
        op_valid_d   = 1'b0;
        op_code_d    = op_code_q;
        err_d        = 1'b0;
        err_sticky_d = err_sticky_q;
        err_prev_d   = err_prev_q;
        err_cur_d    = err_cur_q;
        cnt_d        = cnt_q;
        if (clear) begin
            state_d      = s_valid ? TRACK : EMPTY;
            prev_d       = s_valid ? s_data : prev_q;
            err_sticky_d = 1'b0;
            err_prev_d   = '0;
            err_cur_d    = '0;
            for (int i = 0; i < 5; i++) cnt_d[i] = '0;
        end else if (s_valid) begin
            state_d = TRACK;
            prev_d  = s_data;
            if (state_q == TRACK) begin
                op_valid_d      = 1'b1;
                op_code_d       = step_code;
                err_d           = (step_code == OP_ERR);
                cnt_d[step_idx] = (cnt_q[step_idx] == '1) ? cnt_q[step_idx] : cnt_q[step_idx] + CONE;
                if (step_code == OP_ERR && !err_sticky_q) begin
                    err_sticky_d = 1'b1;
                    err_prev_d   = prev_q;
                    err_cur_d    = s_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            prev_q       <= '0;
            op_valid_q   <= 1'b0;
            op_code_q    <= OP_HOLD;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_prev_q   <= '0;
            err_cur_q    <= '0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            op_valid_q   <= op_valid_d;
            op_code_q    <= op_code_d;
            err_q        <= err_d;
            err_sticky_q <= err_sticky_d;
            err_prev_q   <= err_prev_d;
            err_cur_q    <= err_cur_d;
            for (int i = 0; i < 5; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign op_valid   = op_valid_q;
    assign op_code    = op_code_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign err_prev   = err_prev_q;
    assign err_cur    = err_cur_q;
    assign cnt_hold   = cnt_q[0];
    assign cnt_inc    = cnt_q[1];
    assign cnt_dec    = cnt_q[2];
    assign cnt_neg    = cnt_q[3];
    assign cnt_err    = cnt_q[4];
endmodule

// File: tb/tb_counter_step_decoder.sv
// tb_counter_step_decoder: two instances (CW=16 and CW=2) share random stimulus and are
// checked every cycle against an integer-arithmetic model with uncapped event counts.
module tb_counter_step_decoder;
    localparam int M = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;

    logic        a_valid, a_err, a_sticky, b_valid, b_err, b_sticky;
    logic [2:0]  a_code, b_code;
    logic [7:0]  a_eprev, a_ecur, b_eprev, b_ecur;
    logic [15:0] a_cnt [5];
    logic [1:0]  b_cnt [5];

    int  n_vec = 0;
    int  n_bad = 0;
    bit  run = 1'b0;

    bit  m_have, m_valid, m_err, m_sticky;
    int  m_ref, m_code, m_eprev, m_ecur;
    int  m_cnt [5];

    always #5 clk = ~clk;

    counter_step_decoder #(.N(8), .CW(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_data(s_data),
        .op_valid(a_valid), .op_code(a_code), .err(a_err), .err_sticky(a_sticky),
        .err_prev(a_eprev), .err_cur(a_ecur), .cnt_hold(a_cnt[0]), .cnt_inc(a_cnt[1]),
        .cnt_dec(a_cnt[2]), .cnt_neg(a_cnt[3]), .cnt_err(a_cnt[4])
    );

    counter_step_decoder #(.N(8), .CW(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .s_valid(s_valid), .s_data(s_data),
        .op_valid(b_valid), .op_code(b_code), .err(b_err), .err_sticky(b_sticky),
        .err_prev(b_eprev), .err_cur(b_ecur), .cnt_hold(b_cnt[0]), .cnt_inc(b_cnt[1]),
        .cnt_dec(b_cnt[2]), .cnt_neg(b_cnt[3]), .cnt_err(b_cnt[4])
    );

    function automatic int classify(int p, int d);
        if (d == p) return 0;
        if (d == (p + 1) % M) return 1;
        if (d == (p + M - 1) % M) return 2;
        if (d == (M - p) % M) return 3;
        return 7;
    endfunction

    function automatic int sat(int c, int cw);
        return (c > (1 << cw) - 1) ? (1 << cw) - 1 : c;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: what each output must be after every clock edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_have <= 0; m_ref <= 0; m_valid <= 0; m_code <= 0; m_err <= 0;
            m_sticky <= 0; m_eprev <= 0; m_ecur <= 0;
            for (int i = 0; i < 5; i++) m_cnt[i] <= 0;
        end else if (clear) begin
            m_valid <= 0; m_err <= 0; m_sticky <= 0; m_eprev <= 0; m_ecur <= 0;
            for (int i = 0; i < 5; i++) m_cnt[i] <= 0;
            m_have <= s_valid;
            if (s_valid) m_ref <= int'(s_data);
        end else begin
            m_valid <= 0;
            m_err <= 0;
            if (s_valid) begin
                if (m_have) begin
                    automatic int c = classify(m_ref, int'(s_data));
                    m_valid <= 1;
                    m_code <= c;
                    m_err <= (c == 7);
                    m_cnt[c == 7 ? 4 : c] <= m_cnt[c == 7 ? 4 : c] + 1;
                    if (c == 7 && !m_sticky) begin
                        m_sticky <= 1; m_eprev <= m_ref; m_ecur <= int'(s_data);
                    end
                end
                m_have <= 1;
                m_ref <= int'(s_data);
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            n_vec++;
            check("a.op_valid", a_valid, m_valid);
            check("a.op_code", a_code, m_code);
            check("a.err", a_err, m_err);
            check("a.err_sticky", a_sticky, m_sticky);
            check("a.err_prev", a_eprev, m_eprev);
            check("a.err_cur", a_ecur, m_ecur);
            check("b.op_valid", b_valid, m_valid);
            check("b.op_code", b_code, m_code);
            check("b.err", b_err, m_err);
            check("b.err_sticky", b_sticky, m_sticky);
            for (int i = 0; i < 5; i++) begin
                check($sformatf("a.cnt[%0d]", i), a_cnt[i], sat(m_cnt[i], 16));
                check($sformatf("b.cnt[%0d]", i), b_cnt[i], sat(m_cnt[i], 2));
            end
        end
    end

    task automatic step(input bit c, input bit v, input logic [7:0] d);
        clear = c;
        s_valid = v;
        s_data = d;
        @(negedge clk);
    endtask

    task automatic sample(input logic [7:0] d);
        step(0, 1, d);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst.a.op_valid", a_valid, 0);
        check("rst.a.cnt_inc", a_cnt[1], 0);
        check("rst.b.cnt_inc", b_cnt[1], 0);
        check("rst.a.err_sticky", a_sticky, 0);
        clear = 0;
        s_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] last;
        logic [7:0] d;
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset.op_code", a_code, 0);
        check("reset.cnt_hold", a_cnt[0], 0);
        rst_n = 1'b1;
        sample(5);   check("first.op_valid", a_valid, 0);
        sample(6);   check("5-6.code", a_code, 1);
        sample(7);   check("6-7.code", a_code, 1);
        sample(6);   check("7-6.code", a_code, 2);
        sample(6);   check("6-6.code", a_code, 0);
        check("seq.cnt_inc", a_cnt[1], 2);
        check("seq.cnt_dec", a_cnt[2], 1);
        check("seq.cnt_hold", a_cnt[0], 1);
        check("seq.sticky", a_sticky, 0);
        step(1, 0, 0);
        sample(255);
        sample(0);   check("255-0.code", a_code, 1);
        sample(255); check("0-255.code", a_code, 2);
        check("wrap.cnt_err", a_cnt[4], 0);
        step(1, 1, 12);
        sample(244); check("12-244.code", a_code, 3);
        sample(12);  check("244-12.code", a_code, 3);
        check("neg.cnt_neg", a_cnt[3], 2);
        step(1, 1, 0);
        sample(0);   check("0-0.code", a_code, 0);
        step(1, 1, 128);
        sample(128); check("128-128.code", a_code, 0);
        check("128.cnt_hold", a_cnt[0], 1);
        check("128.cnt_neg", a_cnt[3], 0);
        step(1, 1, 10);
        sample(13);  check("10-13.code", a_code, 7); check("10-13.err", a_err, 1);
        sample(20);  check("13-20.err", a_err, 1);
        check("err.prev", a_eprev, 10);
        check("err.cur", a_ecur, 13);
        check("err.cnt_err", a_cnt[4], 2);
        check("err.sticky", a_sticky, 1);
        step(1, 1, 50);
        check("clr.op_valid", a_valid, 0);
        check("clr.cnt_err", a_cnt[4], 0);
        check("clr.sticky", a_sticky, 0);
        check("clr.err_prev", a_eprev, 0);
        sample(51);  check("50-51.code", a_code, 1); check("51.cnt_inc", a_cnt[1], 1);
        for (int i = 52; i < 58; i++) sample(8'(i));
        check("sat.b.cnt_inc", b_cnt[1], 3);
        check("sat.a.cnt_inc", a_cnt[1], 7);
        pulse_reset();
        sample(100); check("post_rst.op_valid", a_valid, 0);
        sample(101); check("post_rst.code", a_code, 1);
        last = 8'd101;
        for (int n = 0; n < 4000; n++) begin
            int sel;
            sel = $urandom_range(0, 5);
            d = (sel == 0) ? last : (sel == 1) ? last + 8'd1 : (sel == 2) ? last - 8'd1 :
                (sel == 3) ? ~last + 8'd1 : 8'($urandom);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            else begin
                step($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0, d);
                if (s_valid) last = d;
            end
        end
        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/counter_step_decoder.md
Name: counter_step_decoder

Overview:
- Receive-side checker for the N-bit up/down counter value stream (y), driven by a selector or bus.
- Samples successive counter values and decodes which counter operation produced each step: HOLD, INC, DEC, NEG (two's-complement), or ERR.
- Keeps per-operation saturating event counts and captures the first illegal transition for debug.
- Sits downstream of the counter, in the same clock domain.

Parameters:
- N, 8, width of the sampled counter value; legal range N >= 2.
- CW, 16, width of each event counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous clear: forgets the reference value, zeroes counters, clears error state.
- s_valid  input  1  s_data holds a new counter sample this cycle.
- s_data  input  N  sampled counter value.
- op_valid  output  1  one-cycle pulse: op_code is valid.
- op_code  output  3  decoded step: 0 HOLD, 1 INC, 2 DEC, 3 NEG, 7 ERR; other codes unused.
- err  output  1  one-cycle pulse, coincident with op_valid when op_code = ERR.
- err_sticky  output  1  set on the first ERR; held until clear or reset.
- err_prev  output  N  reference value at the first ERR.
- err_cur  output  N  sample value at the first ERR.
- cnt_hold, cnt_inc, cnt_dec, cnt_neg, cnt_err  output  CW each  saturating event counts.

Behaviour:
- Reset (rst_n low, async): state = EMPTY; prev = 0; op_valid = 0; op_code = 0; err = 0; err_sticky = 0; err_prev = 0; err_cur = 0; all cnt_* = 0.
- FSM has two states:
  - EMPTY: no reference value is held. On s_valid: prev <= s_data, go to TRACK, no op_valid pulse.
  - TRACK: on s_valid, classify s_data (d) against prev (p) using mod 2^N arithmetic, then prev <= d.
- Classification priority, first match wins:
  - d == p -> HOLD.
  - d == p+1 -> INC.
  - d == p-1 -> DEC.
  - d == (~p)+1 -> NEG.
  - otherwise -> ERR.
- Wrap-around is legal and decodes as follows:
  - p = 2^N-1, d = 0 -> INC.
  - p = 0, d = 2^N-1 -> DEC.
- NEG is indistinguishable from HOLD when p = 0 or p = 2^(N-1). Both cases decode as HOLD and count in cnt_hold. For N >= 2 there are no other overlaps.
- Latency: op_valid, op_code and err are registered one cycle after the s_valid cycle.
  - op_valid = 0 in every cycle not following a TRACK-state sample.
  - op_code holds its last value between pulses.
- Counters: the matching cnt_* increments by 1 in the same cycle op_valid rises, and saturates at 2^CW-1 (no wrap).
- First-error capture:
  - err_prev and err_cur load only when an ERR occurs while err_sticky = 0.
  - Later ERRs increment cnt_err only.
- clear (synchronous, highest priority over s_valid):
  - Zeroes all cnt_*, err_sticky, err_prev and err_cur; forces op_valid = 0 and err = 0 next cycle.
  - If s_valid is also high, s_data becomes the new reference: state = TRACK, prev = s_data, no decode.
  - Otherwise state = EMPTY.
- s_valid low: no state change. Gaps between samples are allowed, and the next sample is compared with the last accepted one.
- Async reset asserted mid-stream: all state returns to reset values immediately. The first sample after release only loads the reference.

Test Plan:
- Reset, then samples 5,6,7,6,6 -> no pulse for 5; op_codes INC, INC, DEC, HOLD; cnt_inc = 2, cnt_dec = 1, cnt_hold = 1, err_sticky = 0.
- Samples 255,0,255 (N=8) -> INC then DEC; cnt_err = 0.
- Samples 12,244,12, then 0,0 and 128,128 -> NEG, NEG, then HOLD for 0->0 and HOLD for 128->128; cnt_neg = 2.
- Samples 10,13,20 -> ERR pulses on 13 and on 20; err_prev = 10, err_cur = 13 retained; cnt_err = 2; err_sticky = 1.
- clear and s_valid (data 50) in the same cycle, then sample 51 -> counters and error state zeroed, no pulse in the clear cycle, then INC with cnt_inc = 1.
- CW=2, six consecutive INC samples -> cnt_inc saturates at 3. Assert rst_n mid-stream -> outputs zero immediately; the next sample produces no op_valid.
